// File: rtl/vec_pkg.sv
// Shared defaults, opcode map and sequencer state encoding for the vector issue sequencer.
package vec_pkg;

    localparam int DEF_BITS  = 8;
    localparam int DEF_ALUOP = 4;
    localparam int DEF_LANES = 4;

    localparam int OP_MOVE = 1;
    localparam int OP_ADD  = 2;
    localparam int OP_SUB  = 3;
    localparam int OP_AND  = 4;
    localparam int OP_OR   = 5;
    localparam int OP_XOR  = 6;
    localparam int OP_SHL  = 7;
    localparam int OP_SHR  = 8;
    localparam int OP_ROL  = 9;
    localparam int OP_ROR  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } vecState_t;

endpackage

// File: rtl/vec_lane_mux.sv
// Picks the operands for one lane out of the registered source vectors; B can be
// broadcast from lane 0 for vector-scalar operations.
module vec_lane_mux #(
    parameter int BITS  = 8,
    parameter int LANES = 4,
    parameter int LEN_W = 3
) (
    input  logic [LANES*BITS-1:0] vecA,
    input  logic [LANES*BITS-1:0] vecB,
    input  logic                  scalar,
    input  logic [LEN_W-1:0]      laneIdx,
    output logic [BITS-1:0]       laneA,
    output logic [BITS-1:0]       laneB
);

    always_comb begin
        laneA = '0;
        laneB = '0;
        for (int i = 0; i < LANES; i++) begin
            if (laneIdx == LEN_W'(i)) begin
                laneA = vecA[i*BITS +: BITS];
                laneB = scalar ? vecB[BITS-1:0] : vecB[i*BITS +: BITS];
            end
        end
    end

endmodule

// File: rtl/vec_issue_seq.sv
// Serialises one vector instruction onto a shared single-lane ALU, one lane per cycle.
// Optional build macro VEC_SEQ_ILLEGAL_OP_EN rejects opcodes outside 1..10 with outErr.
module vec_issue_seq
    import vec_pkg::*;
#(
    parameter int BITS  = DEF_BITS,
    parameter int ALUOP = DEF_ALUOP,
    parameter int LANES = DEF_LANES
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic                        inValid,
    output logic                        inReady,
    input  logic [ALUOP-1:0]            inOp,
    input  logic [LANES*BITS-1:0]       inVecA,
    input  logic [LANES*BITS-1:0]       inVecB,
    input  logic                        inScalar,
    input  logic [$clog2(LANES):0]      inLen,
    output logic [ALUOP-1:0]            aluOP,
    output logic [BITS-1:0]             vectorA,
    output logic [BITS-1:0]             vectorB,
    input  logic [BITS-1:0]             aluResult,
    output logic                        outValid,
    input  logic                        outReady,
    output logic [LANES*BITS-1:0]       outVec,
    output logic [LANES-1:0]            outMask,
    output logic                        outErr,
    output logic [1:0]                  dbgState
);

    localparam int LEN_W = $clog2(LANES) + 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends on ready, and the producer holds its payload until the transfer.

    vecState_t state, stateNext;

    logic                  readyArm;
    logic [ALUOP-1:0]      opReg;
    logic [LANES*BITS-1:0] aReg;
    logic [LANES*BITS-1:0] bReg;
    logic                  scalarReg;
    logic [LEN_W-1:0]      lenReg;
    logic [LEN_W-1:0]      laneIdx;
    logic [LANES*BITS-1:0] vecReg;
    logic [LANES-1:0]      maskReg;
    logic [LEN_W-1:0]      lenClamped;
    logic                  opIllegal;
    logic                  accept;
    logic                  lastLane;
    logic [BITS-1:0]       laneA;
    logic [BITS-1:0]       laneB;

    assign lenClamped = (inLen > LEN_W'(LANES)) ? LEN_W'(LANES) : inLen;
    assign inReady    = (state == IDLE) && readyArm;
    assign accept     = inValid && inReady;
    assign lastLane   = (laneIdx == (lenReg - LEN_W'(1)));

`ifdef VEC_SEQ_ILLEGAL_OP_EN
    logic errReg;
    assign opIllegal = (inOp < ALUOP'(OP_MOVE)) || (inOp > ALUOP'(OP_ROR));
    assign outErr    = errReg;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            errReg <= 1'b0;
        end else if (accept) begin
            errReg <= opIllegal;
        end
    end
`else
    assign opIllegal = 1'b0;
    assign outErr    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (opIllegal || (lenClamped == '0)) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (lastLane) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (outReady) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // readyArm keeps inReady low until the first edge after reset release.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            readyArm  <= 1'b0;
            opReg     <= '0;
            aReg      <= '0;
            bReg      <= '0;
            scalarReg <= 1'b0;
            lenReg    <= '0;
            laneIdx   <= '0;
            vecReg    <= '0;
            maskReg   <= '0;
        end else begin
            readyArm <= 1'b1;
            if (accept) begin
                opReg     <= inOp;
                aReg      <= inVecA;
                bReg      <= inVecB;
                scalarReg <= inScalar;
                lenReg    <= lenClamped;
                laneIdx   <= '0;
                vecReg    <= '0;
                maskReg   <= '0;
            end else if (state == ISSUE) begin
                for (int i = 0; i < LANES; i++) begin
                    if (laneIdx == LEN_W'(i)) begin
                        vecReg[i*BITS +: BITS] <= aluResult;
                        maskReg[i]             <= 1'b1;
                    end
                end
                laneIdx <= laneIdx + LEN_W'(1);
            end
        end
    end

    vec_lane_mux #(
        .BITS  (BITS),
        .LANES (LANES),
        .LEN_W (LEN_W)
    ) uLaneMux (
        .vecA    (aReg),
        .vecB    (bReg),
        .scalar  (scalarReg),
        .laneIdx (laneIdx),
        .laneA   (laneA),
        .laneB   (laneB)
    );

    assign aluOP    = (state == ISSUE) ? opReg : '0;
    assign vectorA  = (state == ISSUE) ? laneA : '0;
    assign vectorB  = (state == ISSUE) ? laneB : '0;
    assign outValid = (state == DONE);
    assign outVec   = vecReg;
    assign outMask  = maskReg;
    assign dbgState = state;

endmodule

// File: doc/vec_issue_seq.md
VEC_ISSUE_SEQ -- requirements
Module: vec_issue_seq

Interface
REQ-001 SHALL have parameter BITS, default 8: element width in bits.
REQ-002 SHALL have parameter ALUOP, default 4: ALU opcode width.
REQ-003 SHALL have parameter LANES, default 4: elements per vector.
REQ-004 SHALL have ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rstN  in  1  reset; asynchronous, active-low.
- inValid  in  1  instruction offered.
- inReady  out  1  instruction accepted when inValid&&inReady.
- inOp  in  ALUOP  opcode for every lane.
- inVecA  in  LANES*BITS  source A; lane i = bits [i*BITS +: BITS].
- inVecB  in  LANES*BITS  source B.
- inScalar  in  1  when 1, lane 0 of inVecB is broadcast to all lanes.
- inLen  in  $clog2(LANES)+1  active lane count.
- aluOP  out  ALUOP  opcode to the single-lane ALU.
- vectorA  out  BITS  ALU operand A.
- vectorB  out  BITS  ALU operand B.
- aluResult  in  BITS  combinational ALU result for the current operands.
- outValid  out  1  result vector available.
- outReady  in  1  result consumed when outValid&&outReady.
- outVec  out  LANES*BITS  assembled result.
- outMask  out  LANES  bit i = lane i written.
- outErr  out  1  illegal-opcode flag (see Configuration).

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, DONE.
REQ-006 SHALL assert inReady only in IDLE.
REQ-007 On accept in cycle T, SHALL register op, A, B, scalar flag and length, and SHALL go to ISSUE; if inLen=0, SHALL go directly to DONE.
REQ-008 SHALL clamp inLen>LANES to LANES.
REQ-009 In ISSUE, SHALL drive lane i in cycle T+1+i, driving aluOP=op, vectorA=A[i] and vectorB=(scalar ? B[0] : B[i]).
REQ-010 SHALL capture aluResult into outVec lane i in the cycle lane i is driven, and SHALL set outMask[i].
REQ-011 After the last active lane, SHALL enter DONE, so that outValid is first high in cycle T+1+len.
REQ-012 Lanes not issued SHALL read 0 in outVec and 0 in outMask.
REQ-013 Outside ISSUE, SHALL drive aluOP, vectorA and vectorB to 0.
REQ-014 In DONE, SHALL hold outValid high with outVec, outMask and outErr stable until outReady; on the handshake SHALL return to IDLE.
REQ-015 SHALL ignore inValid and all in* changes outside IDLE.
REQ-016 SHALL not issue the next instruction until one IDLE cycle after the DONE handshake.

Reset
REQ-017 While rstN=0, SHALL force state to IDLE and all registers to 0: outValid=0, outVec=0, outMask=0, outErr=0, aluOP=0, vectorA=0, vectorB=0.
REQ-018 SHALL hold inReady=0 while rstN=0, and SHALL drive inReady=1 from the first clock edge after rstN rises.
REQ-019 Reset asserted mid-ISSUE or in DONE SHALL discard the in-flight instruction with no partial output.

Configuration
REQ-020 With VEC_SEQ_ILLEGAL_OP_EN defined, an accepted inOp outside 1..10 SHALL issue no lanes, SHALL go to DONE, and SHALL present outErr=1, outVec=0, outMask=0 at T+1.
REQ-021 Without VEC_SEQ_ILLEGAL_OP_EN, outErr SHALL be tied 0 and illegal opcodes SHALL be issued normally.

Structure
REQ-022 Package vec_pkg SHALL hold BITS, ALUOP and LANES defaults, opcode constants OP_MOVE=1 .. OP_ROR=10, and the FSM state enum.
REQ-023 Sub-module vec_lane_mux SHALL perform lane-index operand extraction and scalar broadcast; the ALU SHALL stay external.

Verification
REQ-024 Reset: rstN=0 with inValid=1 -> inReady=0, outValid=0, aluOP=0; after release -> inReady=1.
REQ-025 ADD: op=2, len=4, A=0x04030201, B=0x01010101 -> aluOP=2 in T+1..T+4, outVec=0x05040302, outMask=4'hF, outValid at T+5.
REQ-026 Scalar shift: op=7, inScalar=1, B lane0=2, A=0x80402010, len=4 -> vectorB=2 every lane, outVec=0x00008040.
REQ-027 Partial and zero length: len=2 -> outMask=4'b0011 with upper lanes 0; len=0 -> outValid at T+1, outMask=0.
REQ-028 Backpressure: outReady=0 for 3 cycles -> outVec stable and inReady=0; outReady=1 -> IDLE next cycle.
REQ-029 Illegal op 4'hC and mid-ISSUE reset: with the macro -> outErr=1 with no lanes issued; reset at lane 2 -> IDLE and outValid never asserted.
